move_request_arbiter: RTL and testbench

//  Collects the single-cycle press pulses from the four direction-button debouncers
//  (up/down/left/right). Arbitrates simultaneous or overlapping presses round-robin.

---
 rtl/move_request_arbiter.sv | 112 +++++++++++
 tb/tb_move_request_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/move_request_arbiter.sv
// Round-robin arbiter and move FIFO between the direction-button debouncers and the player FSM.
// Optional saturating drop counter on o_drop_cnt is built when DROP_CNT_EN is defined.
module move_request_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int DCW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    i_pulse,
  output logic          o_valid,
  output logic [1:0]    o_dir,
  input  logic          i_ready,
  output logic [AW:0]   o_count
`ifdef DROP_CNT_EN
  ,
  output logic [DCW-1:0] o_drop_cnt
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

`ifdef DROP_CNT_EN
  function automatic logic [2:0] popcount4(input logic [3:0] m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

  function automatic logic [DCW-1:0] sat_add(input logic [DCW-1:0] a, input logic [2:0] b);
    logic [DCW:0] s;
    s = {1'b0, a} + (DCW+1)'(b);
    return s[DCW] ? {DCW{1'b1}} : s[DCW-1:0];
  endfunction
`endif

  logic [3:0]    pend_p0;
  logic [1:0]    rr_ptr_p0;
  logic [1:0]    mem_p1 [DEPTH];
  logic [AW-1:0] wr_ptr_p1;
  logic [AW-1:0] rd_ptr_p1;
  logic [AW:0]   count_p1;

  logic          pop;
  logic          push_ok;
  logic          found;
  logic [1:0]    gnt_idx;
  logic [1:0]    idx;
  logic          push;
  logic [3:0]    gnt_oh;

  assign o_valid = (count_p1 != '0);
  assign o_dir   = o_valid ? mem_p1[rd_ptr_p1] : 2'd0;
  assign o_count = count_p1;
  assign pop     = o_valid && i_ready;
  assign push_ok = (count_p1 < FULL_CNT) || pop;

  // Stage 0 -> 1: round-robin search over registered pending, starting at the RR pointer
  always_comb begin
    found   = 1'b0;
    gnt_idx = 2'd0;
    idx     = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr_p0 + 2'(i);
      if (!found && pend_p0[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    push   = found && push_ok;
    gnt_oh = push ? (4'b0001 << gnt_idx) : 4'b0000;
  end

  // A pulse on a bit that is pending and not being granted is lost; a pulse that
  // coincides with its own grant re-arms the bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_p0   <= 4'b0000;
      rr_ptr_p0 <= 2'd0;
    end else begin
      pend_p0 <= (pend_p0 & ~gnt_oh) | i_pulse;
      if (push) rr_ptr_p0 <= gnt_idx + 2'd1;
    end
  end

  // Stage 1: move FIFO
  always_ff @(posedge clk) begin
    if (push) mem_p1[wr_ptr_p1] <= gnt_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_p1 <= '0;
      rd_ptr_p1 <= '0;
      count_p1  <= '0;
    end else begin
      if (push) wr_ptr_p1 <= wr_ptr_p1 + AW'(1);
      if (pop)  rd_ptr_p1 <= rd_ptr_p1 + AW'(1);
      if (push && !pop)      count_p1 <= count_p1 + (AW+1)'(1);
      else if (pop && !push) count_p1 <= count_p1 - (AW+1)'(1);
    end
  end

`ifdef DROP_CNT_EN
  logic [3:0] drop_mask;
  assign drop_mask = i_pulse & pend_p0 & ~gnt_oh;

  always_ff @(posedge clk) begin
    if (rst) o_drop_cnt <= '0;
    else     o_drop_cnt <= sat_add(o_drop_cnt, popcount4(drop_mask));
  end
`endif

endmodule

// File: tb/tb_move_request_arbiter.sv
// Directed bench for move_request_arbiter: vector table plus hand sequences for backpressure, drops and reset.
module tb_move_request_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] i_pulse = 4'b0000;
  logic       i_ready = 1'b0;
  logic       o_valid;
  logic [1:0] o_dir;
  logic [2:0] o_count;
`ifdef DROP_CNT_EN
  logic [7:0] o_drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  move_request_arbiter #(.DEPTH(4), .DCW(8)) dut (
    .clk(clk),
    .rst(rst),
    .i_pulse(i_pulse),
    .o_valid(o_valid),
    .o_dir(o_dir),
    .i_ready(i_ready),
    .o_count(o_count)
`ifdef DROP_CNT_EN
    ,
    .o_drop_cnt(o_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] pulse;
    logic       ready;
    logic       ev;
    logic [1:0] ed;
    logic [2:0] ec;
  } vec_t;

  vec_t vt [25];

  // Inputs are applied at a negedge and consumed by the following posedge.
  task automatic tick(input logic r, input logic [3:0] p, input logic rd);
    rst = r;
    i_pulse = p;
    i_ready = rd;
    @(negedge clk);
    rst = 1'b0;
    i_pulse = 4'b0000;
  endtask

  task automatic check(input string name, input logic ev, input logic [1:0] ed, input logic [2:0] ec);
    total++;
    if (o_valid !== ev || o_dir !== ed || o_count !== ec) begin
      bad++;
      $display("FAIL %s: got valid=%0b dir=%0d count=%0d, want valid=%0b dir=%0d count=%0d",
               name, o_valid, o_dir, o_count, ev, ed, ec);
    end
  endtask

  task automatic set_vec(input int i, input logic r, input logic [3:0] p,
                         input logic ev, input logic [1:0] ed, input logic [2:0] ec);
    vt[i] = '{rst: r, pulse: p, ready: 1'b1, ev: ev, ed: ed, ec: ec};
  endtask

  initial begin
    // single press
    set_vec(0,  0, 4'b0100, 0, 0, 0);
    set_vec(1,  0, 4'b0000, 0, 0, 0);
    set_vec(2,  0, 4'b0000, 1, 2, 1);
    set_vec(3,  0, 4'b0000, 0, 0, 0);
    // simultaneous press, with a re-press of up in the cycle up is granted
    set_vec(4,  1, 4'b0000, 0, 0, 0);
    set_vec(5,  0, 4'b1111, 0, 0, 0);
    set_vec(6,  0, 4'b0001, 0, 0, 0);
    set_vec(7,  0, 4'b0000, 1, 0, 1);
    set_vec(8,  0, 4'b0000, 1, 1, 1);
    set_vec(9,  0, 4'b0000, 1, 2, 1);
    set_vec(10, 0, 4'b0000, 1, 3, 1);
    set_vec(11, 0, 4'b0000, 1, 0, 1);
    set_vec(12, 0, 4'b0000, 0, 0, 0);
    // RR fairness: 0,1 then 0,1 with pointer wrapping from 2
    set_vec(13, 1, 4'b0000, 0, 0, 0);
    set_vec(14, 0, 4'b0011, 0, 0, 0);
    set_vec(15, 0, 4'b0000, 0, 0, 0);
    set_vec(16, 0, 4'b0000, 1, 0, 1);
    set_vec(17, 0, 4'b0000, 1, 1, 1);
    set_vec(18, 0, 4'b0000, 0, 0, 0);
    set_vec(19, 0, 4'b0011, 0, 0, 0);
    set_vec(20, 0, 4'b0000, 0, 0, 0);
    set_vec(21, 0, 4'b0000, 1, 0, 1);
    set_vec(22, 0, 4'b0000, 1, 1, 1);
    set_vec(23, 0, 4'b0000, 0, 0, 0);
    set_vec(24, 0, 4'b0000, 0, 0, 0);

    tick(1, 4'b0000, 0);
    tick(1, 4'b0000, 0);
    check("reset", 0, 0, 0);
`ifdef DROP_CNT_EN
    total++;
    if (o_drop_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_drop: got %0d want 0", o_drop_cnt);
    end
`endif

    for (int i = 0; i < 25; i++) begin
      check($sformatf("vec%0d", i), vt[i].ev, vt[i].ed, vt[i].ec);
      tick(vt[i].rst, vt[i].pulse, vt[i].ready);
    end

    // backpressure: five successive presses with the consumer stalled
    begin
      logic [1:0] dirs [5] = '{0, 1, 2, 3, 0};
      logic [2:0] cnts [5] = '{4, 4, 3, 2, 1};
      tick(1, 4'b0000, 0);
      tick(0, 4'b0001, 0);
      tick(0, 4'b0010, 0);
      tick(0, 4'b0100, 0);
      tick(0, 4'b1000, 0);
      tick(0, 4'b0001, 0);
      tick(0, 4'b0000, 0);
      tick(0, 4'b0000, 0);
      check("bp_full", 1, 0, 4);
      tick(0, 4'b0000, 0);
      check("bp_stable", 1, 0, 4);
      for (int i = 0; i < 5; i++) begin
        check($sformatf("bp_drain%0d", i), 1, dirs[i], cnts[i]);
        tick(0, 4'b0000, 1);
      end
      check("bp_empty", 0, 0, 0);
    end

    // drops: down already pending behind a full FIFO, pressed twice more
    begin
      logic [1:0] dirs [5] = '{0, 1, 2, 3, 1};
      logic [2:0] cnts [5] = '{4, 4, 3, 2, 1};
      tick(1, 4'b0000, 0);
      tick(0, 4'b0001, 0);
      tick(0, 4'b0010, 0);
      tick(0, 4'b0100, 0);
      tick(0, 4'b1000, 0);
      tick(0, 4'b0010, 0);
      tick(0, 4'b0010, 0);
      tick(0, 4'b0010, 0);
      check("drop_full", 1, 0, 4);
`ifdef DROP_CNT_EN
      total++;
      if (o_drop_cnt !== 8'd2) begin
        bad++;
        $display("FAIL drop_cnt: got %0d want 2", o_drop_cnt);
      end
`endif
      for (int i = 0; i < 5; i++) begin
        check($sformatf("drop_drain%0d", i), 1, dirs[i], cnts[i]);
        tick(0, 4'b0000, 1);
      end
      check("drop_empty", 0, 0, 0);
    end

    // mid-run reset with three entries queued
    tick(1, 4'b0000, 0);
    tick(0, 4'b0001, 0);
    tick(0, 4'b0010, 0);
    tick(0, 4'b0100, 0);
    tick(0, 4'b0000, 0);
    check("mr_three", 1, 0, 3);
    tick(1, 4'b0000, 0);
    check("mr_cleared", 0, 0, 0);
    tick(0, 4'b1000, 1);
    tick(0, 4'b0000, 1);
    check("mr_right", 1, 3, 1);
    tick(0, 4'b0000, 1);
    check("mr_idle", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
